trig_monitor: RTL and testbench

TRIG_MONITOR -- requirements
Module: trig_monitor

---
 rtl/trig_mon_pkg.sv | 46 ++++
 rtl/trig_edge_capture.sv | 83 ++++++++
 rtl/trig_monitor.sv | 194 +++++++++++++++++++
 tb/tb_trig_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/trig_mon_pkg.sv
// Shared definitions for the trigger monitor: channel count, capture depth,
// FSM state encoding and the table of expected edge timestamps per channel.
package trig_mon_pkg;

    localparam int NUM_CH    = 4;
    localparam int MAX_EDGES = 2;
    // Width of a per-channel pair counter (0..MAX_EDGES) and of a pair index.
    localparam int CAP_CNT_W = $clog2(MAX_EDGES + 1);
    localparam int CAP_IDX_W = $clog2(MAX_EDGES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_EVAL  = 2'd2
    } mon_state_t;

    // Number of (rise, fall) pairs a correct frame shows on each channel.
    function automatic int exp_pairs(input int ch);
        case (ch)
            0:       return 1;   // dg_out1
            1:       return 2;   // dg_out2
            2:       return 1;   // dg_out3
            default: return 2;   // pg_out
        endcase
    endfunction

    // Expected frame-counter value of a given edge; fall selects the falling edge.
    function automatic int exp_ts(input int ch, input int pair, input bit fall);
        case ({ch[1:0], pair[0], fall})
            4'b00_0_0: return 10;
            4'b00_0_1: return 20;
            4'b01_0_0: return 5;
            4'b01_0_1: return 8;
            4'b01_1_0: return 30;
            4'b01_1_1: return 40;
            4'b10_0_0: return 15;
            4'b10_0_1: return 25;
            4'b11_0_0: return 12;
            4'b11_0_1: return 14;
            4'b11_1_0: return 50;
            4'b11_1_1: return 60;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/trig_edge_capture.sv
// Edge detector and timestamp capture for one monitored trigger channel.
// Holds up to MAX_EDGES rise/fall pairs for the frame currently open.
module trig_edge_capture
    import trig_mon_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_ch,
    input  logic [CNT_W-1:0]                i_ts,
    input  logic                            i_en,
    input  logic                            i_clr,
    output logic [CAP_CNT_W-1:0]            o_cnt,
    output logic                            o_open,
    output logic                            o_ovf,
    output logic [MAX_EDGES-1:0][CNT_W-1:0] o_rise_ts,
    output logic [MAX_EDGES-1:0][CNT_W-1:0] o_fall_ts
);

    logic                            r_prev;
    logic [CAP_CNT_W-1:0]            r_cnt, w_cnt_next, w_cnt_m1;
    logic                            r_open, w_open_next;
    logic                            r_ovf, w_ovf_next;
    logic [MAX_EDGES-1:0][CNT_W-1:0] r_rise, w_rise_next;
    logic [MAX_EDGES-1:0][CNT_W-1:0] r_fall, w_fall_next;

    // Next capture state: clear first (new frame), then apply this cycle's edge,
    // so an edge coincident with the clear lands in the fresh frame.
    always_comb begin
        w_cnt_next  = i_clr ? '0   : r_cnt;
        w_open_next = i_clr ? 1'b0 : r_open;
        w_ovf_next  = i_clr ? 1'b0 : r_ovf;
        w_rise_next = i_clr ? '0   : r_rise;
        w_fall_next = i_clr ? '0   : r_fall;
        w_cnt_m1    = w_cnt_next - CAP_CNT_W'(1);
        if (i_en && (i_ch != r_prev)) begin
            if (i_ch) begin
                if (w_cnt_next < CAP_CNT_W'(MAX_EDGES)) begin
                    w_rise_next[w_cnt_next[CAP_IDX_W-1:0]] = i_ts;
                    w_cnt_next  = w_cnt_next + CAP_CNT_W'(1);
                    w_open_next = 1'b1;
                end else begin
                    w_ovf_next = 1'b1;
                end
            end else if (w_open_next) begin
                w_fall_next[w_cnt_m1[CAP_IDX_W-1:0]] = i_ts;
                w_open_next = 1'b0;
            end else begin
                // A fall with no captured rise cannot be represented either,
                // so it poisons the channel the same way a surplus rise does.
                w_ovf_next = 1'b1;
            end
        end
    end

    // Capture registers; the previous-value register runs every cycle so edges
    // are always relative to the preceding cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_open <= 1'b0;
            r_ovf  <= 1'b0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_prev <= i_ch;
            r_cnt  <= w_cnt_next;
            r_open <= w_open_next;
            r_ovf  <= w_ovf_next;
            r_rise <= w_rise_next;
            r_fall <= w_fall_next;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_open    = r_open;
    assign o_ovf     = r_ovf;
    assign o_rise_ts = r_rise;
    assign o_fall_ts = r_fall;

endmodule

// File: rtl/trig_monitor.sv
// Trigger monitor: timestamps edges on four trigger outputs relative to a
// frame-start pulse and checks them against the expected-edge table.
// Optional frame statistics are built only when TRIG_MON_STATS_EN is defined.
module trig_monitor
    import trig_mon_pkg::*;
#(
    parameter int          CNT_W   = 16,
    parameter logic [15:0] TIMEOUT = 16'd4000,
    parameter int          TOL     = 0
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pulse,
    input  logic [3:0]  ch_in,
    input  logic        clr_err,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [3:0]  ch_err,
    output logic        timeout_err,
    output logic [4:0]  err_sticky,
    output logic [15:0] frames_total,
    output logic [15:0] frames_bad
);

    localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W:0] TOL_C     = (CNT_W+1)'(TOL);

    mon_state_t        r_state, w_state_next;
    logic              r_end_by_pulse;
    logic [CNT_W-1:0]  r_fc, w_fc;
    logic              w_frame_open, w_end, w_cap_en, w_cap_clr;
    logic [NUM_CH-1:0] w_match;
    logic              r_frame_done, r_frame_ok, r_tmo;
    logic [3:0]        r_ch_err;
    logic [4:0]        r_sticky;

    // |cap - exp| <= TOL, evaluated at CNT_W+1 bits signed.
    function automatic logic ts_ok(input logic [CNT_W-1:0] cap, input int exp_v);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, cap}) - $signed({1'b0, CNT_W'(exp_v)});
        if (diff[CNT_W]) diff = -diff;
        return diff <= TOL_C;
    endfunction

    // The pulse cycle itself reads as timestamp 0; the register then runs from 1.
    assign w_fc = pulse ? '0 : r_fc;

    // Frame counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fc <= '0;
        else        r_fc <= (&w_fc) ? w_fc : w_fc + CNT_W'(1);
    end

    // A frame is open while ARMED, and during an EVAL that a pulse caused.
    assign w_frame_open = (r_state == ST_ARMED) || ((r_state == ST_EVAL) && r_end_by_pulse);
    assign w_end        = w_frame_open && (pulse || (w_fc == TIMEOUT_C));
    // Edges in the ending cycle go to the next frame only if a pulse opens one.
    assign w_cap_en     = (w_frame_open && !w_end) || pulse;
    assign w_cap_clr    = pulse || w_end;

    // State register and cause of the most recent frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_end_by_pulse <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_end) r_end_by_pulse <= pulse;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (pulse) w_state_next = ST_ARMED;
            ST_ARMED: if (w_end) w_state_next = ST_EVAL;
            ST_EVAL: begin
                if (w_end)                         w_state_next = ST_EVAL;
                else if (r_end_by_pulse || pulse)  w_state_next = ST_ARMED;
                else                               w_state_next = ST_IDLE;
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CAP_CNT_W-1:0]            w_cnt, r_snap_cnt;
            logic                            w_open, w_ovf, r_snap_open, r_snap_ovf;
            logic [MAX_EDGES-1:0][CNT_W-1:0] w_rise, w_fall, r_snap_rise, r_snap_fall;
            logic                            w_ts_ok;

            trig_edge_capture #(.CNT_W(CNT_W)) u_cap (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_ch      (ch_in[gi]),
                .i_ts      (w_fc),
                .i_en      (w_cap_en),
                .i_clr     (w_cap_clr),
                .o_cnt     (w_cnt),
                .o_open    (w_open),
                .o_ovf     (w_ovf),
                .o_rise_ts (w_rise),
                .o_fall_ts (w_fall)
            );

            // Freeze the finished frame's captures for the compare cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_snap_cnt  <= '0;
                    r_snap_open <= 1'b0;
                    r_snap_ovf  <= 1'b0;
                    r_snap_rise <= '0;
                    r_snap_fall <= '0;
                end else if (w_end) begin
                    r_snap_cnt  <= w_cnt;
                    r_snap_open <= w_open;
                    r_snap_ovf  <= w_ovf;
                    r_snap_rise <= w_rise;
                    r_snap_fall <= w_fall;
                end
            end

            // Check every expected timestamp of this channel against the table.
            always_comb begin
                w_ts_ok = 1'b1;
                for (int p = 0; p < MAX_EDGES; p++) begin
                    if (p < exp_pairs(gi)) begin
                        if (!ts_ok(r_snap_rise[p], exp_ts(gi, p, 1'b0)) ||
                            !ts_ok(r_snap_fall[p], exp_ts(gi, p, 1'b1)))
                            w_ts_ok = 1'b0;
                    end
                end
            end

            assign w_match[gi] = (r_snap_cnt == CAP_CNT_W'(exp_pairs(gi))) &&
                                 !r_snap_ovf && !r_snap_open && w_ts_ok;
        end
    endgenerate

    // Verdict registers: updated one cycle after EVAL is entered, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_ch_err     <= '0;
            r_tmo        <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_EVAL);
            if (r_state == ST_EVAL) begin
                r_frame_ok <= &w_match;
                r_ch_err   <= ~w_match;
                r_tmo      <= ~r_end_by_pulse;
            end
        end
    end

    // Sticky error accumulation; a clear alongside a verdict keeps only that verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_sticky <= '0;
        else if (r_frame_done) r_sticky <= clr_err ? {r_tmo, r_ch_err} : (r_sticky | {r_tmo, r_ch_err});
        else if (clr_err)      r_sticky <= '0;
    end

`ifdef TRIG_MON_STATS_EN
    logic [15:0] r_frames_total, r_frames_bad;

    // Saturating frame statistics, counted alongside each verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames_total <= '0;
            r_frames_bad   <= '0;
        end else if (r_state == ST_EVAL) begin
            if (!(&r_frames_total))             r_frames_total <= r_frames_total + 16'd1;
            if (!(&w_match) && !(&r_frames_bad)) r_frames_bad  <= r_frames_bad + 16'd1;
        end
    end

    assign frames_total = r_frames_total;
    assign frames_bad   = r_frames_bad;
`else
    assign frames_total = '0;
    assign frames_bad   = '0;
`endif

    assign frame_done  = r_frame_done;
    assign frame_ok    = r_frame_ok;
    assign ch_err      = r_ch_err;
    assign timeout_err = r_tmo;
    assign err_sticky  = r_sticky;

endmodule

// File: tb/tb_trig_monitor.sv
// Scoreboard bench for trig_monitor: two instances (TOL=0 and TOL=1) share the
// stimulus; expected verdicts are queued per instance and popped on frame_done.
module tb_trig_monitor;

    localparam int FRAME_LEN = 70;
    localparam int V_GOOD    = 0;
    localparam int V_LATE    = 1;
    localparam int V_TRIPLE  = 2;
    localparam int V_JUNK    = 3;

    typedef struct {
        int         cyc;
        logic       ok;
        logic [3:0] ce;
        logic       to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, pulse, clr_err;
    logic [3:0]  ch_in;
    logic        fd0, ok0, to0, fd1, ok1, to1;
    logic [3:0]  ce0, ce1;
    logic [4:0]  st0, st1;
    logic [15:0] tot0, bad0, tot1, bad1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_pulse = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    trig_monitor dut0 (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .ch_in(ch_in), .clr_err(clr_err),
        .frame_done(fd0), .frame_ok(ok0), .ch_err(ce0), .timeout_err(to0),
        .err_sticky(st0), .frames_total(tot0), .frames_bad(bad0)
    );

    trig_monitor #(.TOL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .ch_in(ch_in), .clr_err(clr_err),
        .frame_done(fd1), .frame_ok(ok1), .ch_err(ce1), .timeout_err(to1),
        .err_sticky(st1), .frames_total(tot1), .frames_bad(bad1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hand-written waveform of a frame at time t (t=0 is the pulse cycle).
    function automatic logic [3:0] levels(input int v, input int t);
        logic [3:0] l;
        if (v == V_JUNK) return {(t < 3), 3'b000};
        l[0] = (t >= 10 && t < 20);
        l[1] = (t >= ((v == V_LATE) ? 6 : 5) && t < 8) || (t >= 30 && t < 40);
        l[2] = (t >= 15 && t < 25);
        l[3] = (t >= 12 && t < 14) || (t >= 50 && t < 60);
        if (v == V_TRIPLE) begin
            l[0] = l[0] | (t >= 30 && t < 32) | (t >= 40 && t < 42);
            l[3] = l[3] | (t >= 65);
        end
        return l;
    endfunction

    // Monitor for the TOL=0 instance.
    always @(negedge clk) begin
        if (fd0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_verdict_tol0 actual=frame_done required=none (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("tol0_latency_cycle", cyc, e0.cyc);
                chk("tol0_frame_ok", {31'd0, ok0}, {31'd0, e0.ok});
                chk("tol0_ch_err", {28'd0, ce0}, {28'd0, e0.ce});
                chk("tol0_timeout_err", {31'd0, to0}, {31'd0, e0.to});
            end
        end
    end

    // Monitor for the TOL=1 instance.
    always @(negedge clk) begin
        if (fd1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_verdict_tol1 actual=frame_done required=none (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("tol1_latency_cycle", cyc, e1.cyc);
                chk("tol1_frame_ok", {31'd0, ok1}, {31'd0, e1.ok});
                chk("tol1_ch_err", {28'd0, ce1}, {28'd0, e1.ce});
                chk("tol1_timeout_err", {31'd0, to1}, {31'd0, e1.to});
            end
        end
    end

    // Drive t=1..FRAME_LEN-1 of a frame, then the ending pulse; queue verdicts.
    task automatic run_frame(input int v, input int clr_t, input int chk_t, input logic [4:0] chk_val,
                             input logic ok0e, input logic [3:0] ce0e,
                             input logic ok1e, input logic [3:0] ce1e);
        for (int t = 1; t < FRAME_LEN; t++) begin
            @(posedge clk); #1;
            pulse   = 1'b0;
            ch_in   = levels(v, t);
            clr_err = (t == clr_t);
            if (t == chk_t) begin
                #1;
                chk("err_sticky", {27'd0, st0}, {27'd0, chk_val});
            end
        end
        @(posedge clk); #1;
        pulse   = 1'b1;
        ch_in   = levels(v, FRAME_LEN);
        clr_err = 1'b0;
        q0.push_back('{cyc + 2, ok0e, ce0e, 1'b0});
        q1.push_back('{cyc + 2, ok1e, ce1e, 1'b0});
        last_pulse = cyc;
        $display("frame variant=%0d ended at cycle %0d: expect ok0=%0b ce0=%b ok1=%0b ce1=%b",
                 v, cyc, ok0e, ce0e, ok1e, ce1e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_frame_done"}, {31'd0, fd0}, 32'd0);
        chk({tag, "_frame_ok"}, {31'd0, ok0}, 32'd0);
        chk({tag, "_ch_err"}, {28'd0, ce0}, 32'd0);
        chk({tag, "_timeout_err"}, {31'd0, to0}, 32'd0);
        chk({tag, "_err_sticky"}, {27'd0, st0}, 32'd0);
        chk({tag, "_frames_total"}, {16'd0, tot0}, 32'd0);
        chk({tag, "_frames_bad"}, {16'd0, bad0}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; pulse = 1'b0; clr_err = 1'b0; ch_in = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Open the first frame, then good / late / good / triple+stuck / junk.
        @(posedge clk); #1;
        pulse = 1'b1;
        last_pulse = cyc;
        run_frame(V_GOOD,   -1, -1, 5'b00000, 1'b1, 4'b0000, 1'b1, 4'b0000);
        run_frame(V_LATE,   50, -1, 5'b00000, 1'b0, 4'b0010, 1'b1, 4'b0000);
        run_frame(V_GOOD,   -1,  5, 5'b00010, 1'b1, 4'b0000, 1'b1, 4'b0000);
        run_frame(V_TRIPLE, -1, -1, 5'b00000, 1'b0, 4'b1001, 1'b0, 4'b1001);
        // clr_err at t=2 coincides with the TRIPLE verdict: only its errors stay.
        run_frame(V_JUNK,    2,  5, 5'b01001, 1'b0, 4'b1111, 1'b0, 4'b1111);

        // Let the frame opened by the last pulse die by timeout.
        q0.push_back('{last_pulse + 4002, 1'b0, 4'b1111, 1'b1});
        q1.push_back('{last_pulse + 4002, 1'b0, 4'b1111, 1'b1});
        $display("timeout frame opened at cycle %0d: expect verdict at %0d", last_pulse, last_pulse + 4002);
        @(posedge clk); #1;
        pulse = 1'b0;
        ch_in = 4'd0;
        repeat (4010) @(posedge clk);
        #1;
        chk("err_sticky_after_timeout", {27'd0, st0}, {27'd0, 5'b11111});

        // A pulse in IDLE opens a frame but gives no verdict of its own.
        pulse = 1'b1;
        last_pulse = cyc;
        run_frame(V_GOOD, 3, 10, 5'b00000, 1'b1, 4'b0000, 1'b1, 4'b0000);

        // Abort the frame just opened with a reset at t=30.
        for (int t = 1; t < 30; t++) begin
            @(posedge clk); #1;
            pulse = 1'b0;
            ch_in = levels(V_GOOD, t);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        ch_in = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("midframe_reset");
        rst_n = 1'b1;

        // Fresh frames after reset: 3 good and 2 bad at TOL=0.
        @(posedge clk); #1;
        pulse = 1'b1;
        last_pulse = cyc;
        run_frame(V_GOOD, -1, -1, 5'b00000, 1'b1, 4'b0000, 1'b1, 4'b0000);
        run_frame(V_LATE, -1, -1, 5'b00000, 1'b0, 4'b0010, 1'b1, 4'b0000);
        run_frame(V_GOOD, -1, -1, 5'b00000, 1'b1, 4'b0000, 1'b1, 4'b0000);
        run_frame(V_LATE, -1, -1, 5'b00000, 1'b0, 4'b0010, 1'b1, 4'b0000);
        run_frame(V_GOOD, -1, -1, 5'b00000, 1'b1, 4'b0000, 1'b1, 4'b0000);
        @(posedge clk); #1;
        pulse = 1'b0;
        ch_in = 4'd0;
        repeat (4) @(posedge clk);
        #1;

`ifdef TRIG_MON_STATS_EN
        chk("frames_total_tol0", {16'd0, tot0}, 32'd5);
        chk("frames_bad_tol0",   {16'd0, bad0}, 32'd2);
        chk("frames_total_tol1", {16'd0, tot1}, 32'd5);
        chk("frames_bad_tol1",   {16'd0, bad1}, 32'd0);
`else
        chk("frames_total_tol0", {16'd0, tot0}, 32'd0);
        chk("frames_bad_tol0",   {16'd0, bad0}, 32'd0);
        chk("frames_total_tol1", {16'd0, tot1}, 32'd0);
        chk("frames_bad_tol1",   {16'd0, bad1}, 32'd0);
`endif
        chk("err_sticky_final", {27'd0, st0}, {27'd0, 5'b00010});
        chk("tol0_verdicts_outstanding", q0.size(), 32'd0);
        chk("tol1_verdicts_outstanding", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
